bambu_putchar_arbiter: RTL and testbench



---
 rtl/bambu_io_pkg.sv | 17 +
 rtl/bambu_rr_arbiter.sv | 35 +++
 rtl/bambu_putchar_arbiter.sv | 123 ++++++++++++
 tb/tb_bambu_putchar_arbiter.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/bambu_io_pkg.sv
// Shared definitions for the Bambu HLS character I/O blocks (putchar TX
// arbiter, getchar RX path).
//   ARB_IDLE / ARB_SEND : one-hot encodings of the TX arbiter FSM states
//   CHAR_W              : default character width
//   arb_state_e         : enum view of the two arbiter states
package bambu_io_pkg;

  localparam logic [1:0] ARB_IDLE = 2'b01;
  localparam logic [1:0] ARB_SEND = 2'b10;
  localparam int         CHAR_W   = 8;

  typedef enum logic [1:0] {
    ST_IDLE = ARB_IDLE,
    ST_SEND = ARB_SEND
  } arb_state_e;

endpackage

// File: rtl/bambu_rr_arbiter.sv
// Combinational round-robin picker.
//   req       : request vector, one bit per client
//   last_ptr  : index of the most recently served client
//   gnt_idx   : first requesting client found after last_ptr (wrapping)
//   any_grant : at least one request is present
module bambu_rr_arbiter
  import bambu_io_pkg::*;
#(
  parameter int NUM_CLIENTS = 4,
  parameter int IDX_W       = $clog2(NUM_CLIENTS)
) (
  input  logic [NUM_CLIENTS-1:0] req,
  input  logic [IDX_W-1:0]       last_ptr,
  output logic [IDX_W-1:0]       gnt_idx,
  output logic                   any_grant
);

  int idx;

  // Walk offsets 1..N from the last grant; the last grant itself is tried
  // last so a lone requester can still be re-served.
  always_comb begin
    gnt_idx   = '0;
    any_grant = 1'b0;
    idx       = 0;
    for (int k = 1; k <= NUM_CLIENTS; k++) begin
      idx = (int'(last_ptr) + k) % NUM_CLIENTS;
      if (!any_grant && req[idx]) begin
        any_grant = 1'b1;
        gnt_idx   = idx[IDX_W-1:0];
      end
    end
  end

endmodule

// File: rtl/bambu_putchar_arbiter.sv
// Shares one UART TX byte stream between NUM_CLIENTS Bambu putchar call
// sites. Each start pulse latches a character; latched requests are sent
// in round-robin order over TX_DATA/TX_VALID/TX_READY, and the owning
// client gets a one-cycle done pulse after its byte is accepted.
//   clock, reset : clock, asynchronous active-high reset
//   start_port   : per-client call pulse
//   data_in      : per-client character, client i at [i*DATA_W +: DATA_W]
//   done_port    : per-client completion pulse (registered, one-hot or zero)
//   TX_DATA/TX_VALID/TX_READY : byte stream to the UART serializer
module bambu_putchar_arbiter
  import bambu_io_pkg::*;
#(
  parameter int NUM_CLIENTS = 4,
  parameter int DATA_W      = CHAR_W
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [NUM_CLIENTS-1:0]        start_port,
  input  logic [NUM_CLIENTS*DATA_W-1:0] data_in,
  output logic [NUM_CLIENTS-1:0]        done_port,
  output logic [DATA_W-1:0]             TX_DATA,
  output logic                          TX_VALID,
  input  logic                          TX_READY
);

  localparam int IDX_W = $clog2(NUM_CLIENTS);

  arb_state_e                          state_q, state_d;
  logic [NUM_CLIENTS-1:0]              pending_q, pending_d;
  logic [NUM_CLIENTS-1:0][DATA_W-1:0]  latch_q, latch_d;
  logic [IDX_W-1:0]                    gnt_q, gnt_d;
  logic [IDX_W-1:0]                    ptr_q, ptr_d;
  logic [DATA_W-1:0]                   tx_data_q, tx_data_d;
  logic                                tx_valid_q, tx_valid_d;
  logic [NUM_CLIENTS-1:0]              done_q, done_d;

  logic [IDX_W-1:0]                    arb_gnt;
  logic                                arb_any;

  bambu_rr_arbiter #(
    .NUM_CLIENTS (NUM_CLIENTS),
    .IDX_W       (IDX_W)
  ) u_rr (
    .req       (pending_q),
    .last_ptr  (ptr_q),
    .gnt_idx   (arb_gnt),
    .any_grant (arb_any)
  );

  always_comb begin
    state_d    = state_q;
    pending_d  = pending_q;
    latch_d    = latch_q;
    gnt_d      = gnt_q;
    ptr_d      = ptr_q;
    tx_data_d  = tx_data_q;
    tx_valid_d = tx_valid_q;
    done_d     = '0;

    // A start while already pending is a caller error; keep the first byte.
    for (int i = 0; i < NUM_CLIENTS; i++) begin
      if (start_port[i] && !pending_q[i]) begin
        pending_d[i] = 1'b1;
        latch_d[i]   = data_in[i*DATA_W +: DATA_W];
      end
    end

    // Arbitration only looks at registered pending bits, so a start in the
    // cycle the FSM is idle waits one cycle before it can be granted.
    unique case (state_q)
      ST_IDLE: begin
        if (arb_any) begin
          gnt_d      = arb_gnt;
          tx_data_d  = latch_q[arb_gnt];
          tx_valid_d = 1'b1;
          state_d    = ST_SEND;
        end else begin
          tx_valid_d = 1'b0;
        end
      end
      ST_SEND: begin
        if (TX_READY) begin
          tx_valid_d         = 1'b0;
          pending_d[gnt_q]   = 1'b0;
          done_d[gnt_q]      = 1'b1;
          ptr_d              = gnt_q;
          state_d            = ST_IDLE;
        end
      end
      default: begin
        tx_valid_d = 1'b0;
        state_d    = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      pending_q  <= '0;
      latch_q    <= '0;
      gnt_q      <= '0;
      ptr_q      <= IDX_W'(NUM_CLIENTS - 1);
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
      done_q     <= '0;
    end else begin
      state_q    <= state_d;
      pending_q  <= pending_d;
      latch_q    <= latch_d;
      gnt_q      <= gnt_d;
      ptr_q      <= ptr_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
      done_q     <= done_d;
    end
  end

  assign done_port = done_q;
  assign TX_DATA   = tx_data_q;
  assign TX_VALID  = tx_valid_q;

endmodule

// File: tb/tb_bambu_putchar_arbiter.sv
// Directed bench for bambu_putchar_arbiter (4 clients, 8-bit chars).
// Inputs change 1 time unit after the rising edge and outputs are sampled
// there too; "cycle 0" is the cycle in which a start pulse is driven.
module tb_bambu_putchar_arbiter;

  localparam int N = 4;
  localparam int W = 8;

  logic             clock = 1'b0;
  logic             reset;
  logic [N-1:0]     start_port;
  logic [N*W-1:0]   data_in;
  logic [N-1:0]     done_port;
  logic [W-1:0]     TX_DATA;
  logic             TX_VALID;
  logic             TX_READY;

  int total = 0;
  int bad   = 0;

  bambu_putchar_arbiter #(.NUM_CLIENTS(N), .DATA_W(W)) dut (
    .clock      (clock),
    .reset      (reset),
    .start_port (start_port),
    .data_in    (data_in),
    .done_port  (done_port),
    .TX_DATA    (TX_DATA),
    .TX_VALID   (TX_VALID),
    .TX_READY   (TX_READY)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset;
    reset      = 1'b1;
    start_port = '0;
    data_in    = '0;
    TX_READY   = 1'b1;
    tick;
    tick;
    reset = 1'b0;
    tick;
  endtask

  task automatic test_reset;
    reset      = 1'b1;
    start_port = '0;
    data_in    = '0;
    TX_READY   = 1'b0;
    tick;
    total++; if (TX_VALID !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", TX_VALID); end
    total++; if (TX_DATA !== 8'h00) begin bad++; $display("FAIL reset_data got=%h exp=00", TX_DATA); end
    total++; if (done_port !== 4'b0000) begin bad++; $display("FAIL reset_done got=%b exp=0000", done_port); end
    reset = 1'b0;
    tick; tick; tick;
    total++; if (TX_VALID !== 1'b0) begin bad++; $display("FAIL reset_idle_valid got=%b exp=0", TX_VALID); end
  endtask

  task automatic test_single;
    do_reset;
    start_port = 4'b0001; data_in = 32'h0000_0041;           // cycle 0
    tick; start_port = '0; data_in = '0;                       // cycle 1
    total++; if (TX_VALID !== 1'b0) begin bad++; $display("FAIL single_c1_valid got=%b exp=0", TX_VALID); end
    tick;                                                      // cycle 2
    total++; if (TX_VALID !== 1'b1) begin bad++; $display("FAIL single_c2_valid got=%b exp=1", TX_VALID); end
    total++; if (TX_DATA !== 8'h41) begin bad++; $display("FAIL single_c2_data got=%h exp=41", TX_DATA); end
    total++; if (done_port !== 4'b0000) begin bad++; $display("FAIL single_c2_done got=%b exp=0000", done_port); end
    tick;                                                      // cycle 3
    total++; if (done_port !== 4'b0001) begin bad++; $display("FAIL single_c3_done got=%b exp=0001", done_port); end
    total++; if (TX_VALID !== 1'b0) begin bad++; $display("FAIL single_c3_valid got=%b exp=0", TX_VALID); end
    tick;                                                      // cycle 4
    total++; if (done_port !== 4'b0000) begin bad++; $display("FAIL single_c4_done got=%b exp=0000", done_port); end
  endtask

  task automatic test_backpressure;
    do_reset;
    TX_READY   = 1'b0;
    start_port = 4'b0100; data_in = 32'h005A_0000;            // cycle 0
    tick; start_port = '0; data_in = '0;                       // cycle 1
    tick;                                                      // cycle 2
    for (int c = 0; c < 5; c++) begin                          // cycles 2..6
      total++; if (TX_VALID !== 1'b1) begin bad++; $display("FAIL bp_hold_valid c=%0d got=%b exp=1", c, TX_VALID); end
      total++; if (TX_DATA !== 8'h5A) begin bad++; $display("FAIL bp_hold_data c=%0d got=%h exp=5a", c, TX_DATA); end
      total++; if (done_port !== 4'b0000) begin bad++; $display("FAIL bp_hold_done c=%0d got=%b exp=0000", c, done_port); end
      tick;
    end
    TX_READY = 1'b1;                                           // cycle 7
    total++; if (TX_VALID !== 1'b1) begin bad++; $display("FAIL bp_c7_valid got=%b exp=1", TX_VALID); end
    tick;                                                      // cycle 8
    total++; if (done_port !== 4'b0100) begin bad++; $display("FAIL bp_done got=%b exp=0100", done_port); end
    total++; if (TX_VALID !== 1'b0) begin bad++; $display("FAIL bp_c8_valid got=%b exp=0", TX_VALID); end
  endtask

  task automatic test_simultaneous;
    logic [7:0] exp_d;
    logic [3:0] exp_done;
    do_reset;
    start_port = 4'b1111; data_in = 32'h3332_3130;            // cycle 0
    tick; start_port = '0; data_in = '0;                       // cycle 1
    tick;                                                      // cycle 2
    for (int k = 0; k < 4; k++) begin
      exp_d    = 8'h30 + 8'(k);
      exp_done = 4'b0001 << k;
      total++; if (TX_VALID !== 1'b1 || TX_DATA !== exp_d) begin bad++; $display("FAIL simul_tx k=%0d got=%b/%h exp=1/%h", k, TX_VALID, TX_DATA, exp_d); end
      total++; if (done_port !== 4'b0000) begin bad++; $display("FAIL simul_nodone k=%0d got=%b exp=0000", k, done_port); end
      tick;
      total++; if (done_port !== exp_done) begin bad++; $display("FAIL simul_done k=%0d got=%b exp=%b", k, done_port, exp_done); end
      total++; if (TX_VALID !== 1'b0) begin bad++; $display("FAIL simul_gap k=%0d got=%b exp=0", k, TX_VALID); end
      tick;
    end
    total++; if (TX_VALID !== 1'b0 || done_port !== 4'b0000) begin bad++; $display("FAIL simul_end got=%b/%b exp=0/0000", TX_VALID, done_port); end
  endtask

  task automatic test_fairness;
    do_reset;
    start_port = 4'b0010; data_in = 32'h0000_2100;            // cycle 0
    tick;                                                      // cycle 1
    start_port = 4'b1001; data_in = 32'h2300_0020;
    tick; start_port = '0; data_in = '0;                       // cycle 2
    total++; if (TX_DATA !== 8'h21 || TX_VALID !== 1'b1) begin bad++; $display("FAIL fair_first got=%b/%h exp=1/21", TX_VALID, TX_DATA); end
    tick;                                                      // cycle 3
    total++; if (done_port !== 4'b0010) begin bad++; $display("FAIL fair_done1 got=%b exp=0010", done_port); end
    tick;                                                      // cycle 4
    total++; if (TX_DATA !== 8'h23 || TX_VALID !== 1'b1) begin bad++; $display("FAIL fair_second got=%b/%h exp=1/23", TX_VALID, TX_DATA); end
    tick;                                                      // cycle 5
    total++; if (done_port !== 4'b1000) begin bad++; $display("FAIL fair_done3 got=%b exp=1000", done_port); end
    tick;                                                      // cycle 6
    total++; if (TX_DATA !== 8'h20 || TX_VALID !== 1'b1) begin bad++; $display("FAIL fair_third got=%b/%h exp=1/20", TX_VALID, TX_DATA); end
    tick;                                                      // cycle 7
    total++; if (done_port !== 4'b0001) begin bad++; $display("FAIL fair_done0 got=%b exp=0001", done_port); end
  endtask

  task automatic test_violation;
    do_reset;
    TX_READY   = 1'b0;
    start_port = 4'b0001; data_in = 32'h0000_0010;            // cycle 0
    tick; data_in = 32'h0000_00FF;                             // cycle 1: restart while pending
    tick;                                                      // cycle 2: restart during SEND
    total++; if (TX_DATA !== 8'h10 || TX_VALID !== 1'b1) begin bad++; $display("FAIL viol_data got=%b/%h exp=1/10", TX_VALID, TX_DATA); end
    tick; start_port = '0; data_in = '0; TX_READY = 1'b1;     // cycle 3
    total++; if (TX_DATA !== 8'h10) begin bad++; $display("FAIL viol_hold got=%h exp=10", TX_DATA); end
    tick;                                                      // cycle 4: done cycle, re-issue
    total++; if (done_port !== 4'b0001) begin bad++; $display("FAIL viol_done got=%b exp=0001", done_port); end
    start_port = 4'b0001; data_in = 32'h0000_0011;
    tick; start_port = '0; data_in = '0;                       // cycle 5
    total++; if (TX_VALID !== 1'b0) begin bad++; $display("FAIL viol_gap got=%b exp=0", TX_VALID); end
    tick;                                                      // cycle 6
    total++; if (TX_DATA !== 8'h11 || TX_VALID !== 1'b1) begin bad++; $display("FAIL viol_reissue got=%b/%h exp=1/11", TX_VALID, TX_DATA); end
    tick;                                                      // cycle 7
    total++; if (done_port !== 4'b0001) begin bad++; $display("FAIL viol_done2 got=%b exp=0001", done_port); end
    for (int c = 0; c < 3; c++) begin
      tick;
      total++; if (TX_VALID !== 1'b0) begin bad++; $display("FAIL viol_no_ff c=%0d got=%b/%h exp=0", c, TX_VALID, TX_DATA); end
    end
  endtask

  task automatic test_reset_mid_send;
    do_reset;
    TX_READY   = 1'b0;
    start_port = 4'b0110; data_in = 32'h0062_6100;            // cycle 0
    tick; start_port = '0; data_in = '0;                       // cycle 1
    tick;                                                      // cycle 2
    total++; if (TX_VALID !== 1'b1 || TX_DATA !== 8'h61) begin bad++; $display("FAIL rst_pre got=%b/%h exp=1/61", TX_VALID, TX_DATA); end
    reset = 1'b1;
    #1;
    total++; if (TX_VALID !== 1'b0 || done_port !== 4'b0000) begin bad++; $display("FAIL rst_async got=%b/%b exp=0/0000", TX_VALID, done_port); end
    tick;
    reset    = 1'b0;
    TX_READY = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick;
      total++; if (TX_VALID !== 1'b0 || done_port !== 4'b0000) begin bad++; $display("FAIL rst_quiet c=%0d got=%b/%b exp=0/0000", c, TX_VALID, done_port); end
    end
    start_port = 4'b1001; data_in = 32'h7300_0070;            // cycle 0
    tick; start_port = '0; data_in = '0;
    tick;                                                      // cycle 2
    total++; if (TX_VALID !== 1'b1 || TX_DATA !== 8'h70) begin bad++; $display("FAIL rst_prio got=%b/%h exp=1/70", TX_VALID, TX_DATA); end
    tick;
    total++; if (done_port !== 4'b0001) begin bad++; $display("FAIL rst_done0 got=%b exp=0001", done_port); end
    tick;
    total++; if (TX_VALID !== 1'b1 || TX_DATA !== 8'h73) begin bad++; $display("FAIL rst_next got=%b/%h exp=1/73", TX_VALID, TX_DATA); end
    tick;
    total++; if (done_port !== 4'b1000) begin bad++; $display("FAIL rst_done3 got=%b exp=1000", done_port); end
  endtask

  initial begin
    reset      = 1'b1;
    start_port = '0;
    data_in    = '0;
    TX_READY   = 1'b0;
    test_reset;
    test_single;
    test_backpressure;
    test_simultaneous;
    test_fairness;
    test_violation;
    test_reset_mid_send;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
